// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: register address type, datapath width and
// the writeback requester indices.
package rv32_pkg;
    typedef logic [4:0] regaddr_t;

    localparam int XLEN   = 32;
    localparam int NREQ   = 3;
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to one past the winner when the grant is used.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    int            w_best;
    int            w_best_d;
    int            w_dist;

    // Pick the valid requester with the smallest rotational distance from r_ptr.
    always_comb begin
        w_best    = -1;
        w_best_d  = NREQ;
        w_dist    = 0;
        gnt       = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(r_ptr);
            if (w_dist < 0) w_dist = w_dist + NREQ;
            if (req[i] && (w_dist < w_best_d)) begin
                w_best   = i;
                w_best_d = w_dist;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (i == w_best) begin
                gnt[i]    = 1'b1;
                w_ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: shares the single write port among the
// writeback units and tracks outstanding writes for decode hazard stalls.
module rf_wb_ctrl
    import rv32_pkg::regaddr_t;
#(
    parameter int NREQ = rv32_pkg::NREQ,
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  regaddr_t [NREQ-1:0]       req_rd,
    input  logic [NREQ-1:0][XLEN-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      issue_valid,
    input  regaddr_t                  issue_rs1,
    input  regaddr_t                  issue_rs2,
    input  regaddr_t                  issue_rd,
    input  logic                      issue_wb,
    output logic                      hazard,
    output logic                      rf_wr,
    output regaddr_t                  rf_rd,
    output logic [XLEN-1:0]           rf_wrdata,
    output logic [30:0]               pending
);
    logic [NREQ-1:0] w_gnt;
    logic            w_accept;
    regaddr_t        w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_issue_acc;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;
    logic [31:0]     r_pend;
    logic            r_wr_p1;
    regaddr_t        r_rd_p1;
    logic [XLEN-1:0] r_wrdata_p1;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |(req_valid & w_gnt);

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = req_rd[i];
                w_sel_data = req_data[i];
            end
        end
    end

    // Bit 0 of r_pend is held at zero, so indexing it directly gives P(0) = 0.
    assign hazard      = issue_valid && (r_pend[issue_rs1] || r_pend[issue_rs2] ||
                                         (issue_wb && r_pend[issue_rd]));
    assign w_issue_acc = issue_valid && !hazard;
    assign w_set       = (w_issue_acc && issue_wb) ? (32'd1 << issue_rd) : '0;
    assign w_clr       = r_wr_p1 ? (32'd1 << r_rd_p1) : '0;

    // Set is applied after clear so a newer outstanding write keeps its bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
        end
    end

    // ---- write stage p1: registered register-file port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_p1     <= 1'b0;
            r_rd_p1     <= '0;
            r_wrdata_p1 <= '0;
        end else begin
            r_wr_p1 <= w_accept && (w_sel_rd != '0);
            if (w_accept) begin
                r_rd_p1     <= w_sel_rd;
                r_wrdata_p1 <= w_sel_data;
            end
        end
    end

    assign rf_wr     = r_wr_p1;
    assign rf_rd     = r_rd_p1;
    assign rf_wrdata = r_wrdata_p1;
    assign pending   = r_pend[31:1];
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: per-cycle comparison against a behavioural
// model plus literal expectations for the listed scenarios.
module tb_rf_wb_ctrl;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0][4:0]  req_rd;
    logic [NR-1:0][31:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             issue_valid;
    logic [4:0]       issue_rs1, issue_rs2, issue_rd;
    logic             issue_wb;
    logic             hazard;
    logic             rf_wr;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_wrdata;
    logic [30:0]      pending;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state
    int        m_ptr  = 0;
    bit [31:0] m_pend = '0;
    bit        m_wr   = 1'b0;
    bit [4:0]  m_rd   = '0;
    bit [31:0] m_data = '0;

    rf_wb_ctrl #(.NREQ(NR), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wb    (issue_wb),
        .hazard      (hazard),
        .rf_wr       (rf_wr),
        .rf_rd       (rf_rd),
        .rf_wrdata   (rf_wrdata),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mp(input bit [4:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    // Model compare, then advance model state using this cycle's inputs.
    initial begin
        int g;
        int idx;
        bit exp_haz;
        logic [NR-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                g = -1;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                exp_haz = issue_valid && (mp(issue_rs1) || mp(issue_rs2) || (issue_wb && mp(issue_rd)));

                chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
                chk("m_hazard",    64'(hazard),    64'(exp_haz));
                chk("m_rf_wr",     64'(rf_wr),     64'(m_wr));
                chk("m_rf_rd",     64'(rf_rd),     64'(m_rd));
                chk("m_rf_wrdata", 64'(rf_wrdata), 64'(m_data));
                chk("m_pending",   64'(pending),   64'(m_pend[31:1]));

                if (rst) begin
                    m_ptr = 0; m_pend = '0; m_wr = 0; m_rd = '0; m_data = '0;
                end else begin
                    if (m_wr) m_pend[m_rd] = 1'b0;
                    if (issue_valid && !exp_haz && issue_wb && issue_rd != 0)
                        m_pend[issue_rd] = 1'b1;
                    m_wr = (g >= 0) && (req_rd[g] != 0);
                    if (g >= 0) begin
                        m_rd   = req_rd[g];
                        m_data = req_data[g];
                        m_ptr  = (g + 1) % NR;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_wb = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        // Idle after reset
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd6;
        @(negedge clk);
        chk("idle_rf_wr", 64'(rf_wr), 64'd0);
        chk("idle_pending", 64'(pending), 64'd0);
        chk("idle_hazard", 64'(hazard), 64'd0);
        cyc();

        // Issue rd=5, LSU retires it in cycle 3
        issue_rd = 5'd5; issue_wb = 1'b1; issue_rs1 = '0; issue_rs2 = '0;
        @(negedge clk);
        chk("raw_c0_hazard", 64'(hazard), 64'd0);
        cyc();
        for (int c = 1; c <= 4; c++) begin
            issue_wb = 1'b0; issue_rd = '0; issue_rs1 = 5'd5;
            req_valid = (c == 3) ? 3'b010 : 3'b000;
            req_rd[1] = 5'd5; req_data[1] = 32'hDEADBEEF;
            @(negedge clk);
            chk($sformatf("raw_c%0d_hazard", c), 64'(hazard), 64'd1);
            if (c == 3) chk("raw_c3_ready", 64'(req_ready), 64'b010);
            if (c == 4) begin
                chk("raw_c4_rf_wr", 64'(rf_wr), 64'd1);
                chk("raw_c4_rf_rd", 64'(rf_rd), 64'd5);
                chk("raw_c4_wrdata", 64'(rf_wrdata), 64'hDEADBEEF);
            end
            cyc();
        end
        req_valid = '0;
        @(negedge clk);
        chk("raw_c5_hazard", 64'(hazard), 64'd0);
        chk("raw_c5_rf_wr", 64'(rf_wr), 64'd0);
        cyc();

        // Round-robin with all requesters valid from reset
        issue_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 3'b111;
        req_rd[0] = 5'd1; req_rd[1] = 5'd2; req_rd[2] = 5'd3;
        req_data[0] = 32'h100; req_data[1] = 32'h200; req_data[2] = 32'h300;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 6) chk($sformatf("rr_gnt%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            if (k > 0) begin
                chk($sformatf("rr_rd%0d", k), 64'(rf_rd), 64'((k - 1) % 3 + 1));
                chk($sformatf("rr_wr%0d", k), 64'(rf_wr), 64'd1);
            end
            cyc();
        end
        req_valid = '0;

        // ALU write to x0 is consumed silently
        req_valid = 3'b001; req_rd[0] = 5'd0; req_data[0] = 32'h1234;
        @(negedge clk);
        chk("x0_ready", 64'(req_ready), 64'b001);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("x0_rf_wr", 64'(rf_wr), 64'd0);
        chk("x0_wrdata", 64'(rf_wrdata), 64'h1234);
        chk("x0_pending", 64'(pending), 64'd0);
        cyc();

        // Reissue of rd=7 around its retirement edge
        issue_valid = 1'b1; issue_rd = 5'd7; issue_wb = 1'b1; issue_rs1 = '0; issue_rs2 = '0;
        @(negedge clk);
        chk("r7_issue_hazard", 64'(hazard), 64'd0);
        cyc();
        issue_valid = 1'b0; req_valid = 3'b001; req_rd[0] = 5'd7; req_data[0] = 32'h77;
        @(negedge clk);
        chk("r7_pending_set", 64'(pending[6]), 64'd1);
        cyc();
        req_valid = '0; issue_valid = 1'b1;
        @(negedge clk);
        chk("r7_rf_wr", 64'(rf_wr), 64'd1);
        chk("r7_rf_rd", 64'(rf_rd), 64'd7);
        chk("r7_waw_hazard", 64'(hazard), 64'd1);
        cyc();
        @(negedge clk);
        chk("r7_cleared", 64'(pending[6]), 64'd0);
        chk("r7_reissue_hazard", 64'(hazard), 64'd0);
        cyc();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("r7_pending_again", 64'(pending[6]), 64'd1);
        cyc();

        // Reset while pending[9] is set and an accept is in flight
        issue_valid = 1'b1; issue_rd = 5'd9; issue_wb = 1'b1;
        @(negedge clk);
        cyc();
        issue_valid = 1'b0; req_valid = 3'b001; req_rd[0] = 5'd9; req_data[0] = 32'h99; rst = 1'b1;
        @(negedge clk);
        chk("rst_pending9", 64'(pending[8]), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'b001);
        cyc();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("rst_rf_wr", 64'(rf_wr), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        cyc();
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
